// File: rtl/shift_sequencer.sv
// Multi-bit shift request sequencer: executes a shift as one-bit steps, one per clock.
// Optional rotate mode is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [AMT_W-1:0] req_amt,
    input  logic             req_dir,
    input  logic             req_rot,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [1:0]       shift_enable,
    output logic             busy
);

    // valid/ready: a transfer happens on a rising edge where both valid and ready are high;
    // the source holds its payload stable until that edge.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] step_val;

`ifdef SHIFT_SEQ_ROTATE_EN
    logic rot_q, rot_d;

    always_comb begin
        step_val = '0;
        if (rot_q) begin
            step_val = dir_q ? {op_q[0], op_q[WIDTH-1:1]} : {op_q[WIDTH-2:0], op_q[WIDTH-1]};
        end else begin
            step_val = dir_q ? {1'b0, op_q[WIDTH-1:1]} : {op_q[WIDTH-2:0], 1'b0};
        end
    end
`else
    logic unused_rot;
    assign unused_rot = req_rot;

    always_comb begin
        step_val = '0;
        step_val = dir_q ? {1'b0, op_q[WIDTH-1:1]} : {op_q[WIDTH-2:0], 1'b0};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
`ifdef SHIFT_SEQ_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d  = req_data;
                    cnt_d = req_amt;
                    dir_d = req_dir;
`ifdef SHIFT_SEQ_ROTATE_EN
                    rot_d = req_rot;
`endif
                    state_d = (req_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                op_d  = step_val;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Direction is only meaningful once a request has been captured.
    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign res_valid    = (state_q == DONE);
    assign res_data     = op_q;
    assign shift_enable = {dir_q & (state_q != IDLE), state_q == SHIFT};

endmodule
